// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester main-memory arbiter.
// Holds the FSM state encoding and the requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker: round-robin on ties using a last-grant pointer,
// or requester 1 always wins ties when fixed_prio is set.
module arb_rr2 (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       advance,
    output logic [1:0] win
);

    // 1 means requester 1 was granted last, so requester 0 wins the next tie
    logic last_reg;

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (fixed_prio || !last_reg) ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            last_reg <= 1'b1;
        end else if (advance && (win != 2'b00)) begin
            last_reg <= win[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (requester 0)
// and the load/store path (requester 1), one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_reg, state_next;
    logic              owner_reg;
    logic              cmd_we_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [1:0] req_vec;
    logic [1:0] win;
    logic       advance;
    logic [1:0] gnt_vec;
    logic [1:0] ack_vec;

    assign req_vec = {req1, req0};
    assign advance = (state_reg == ST_IDLE) && (req_vec != 2'b00);

    arb_rr2 u_pick (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req        (req_vec),
        .fixed_prio (FIXED_PRIO != 0),
        .advance    (advance),
        .win        (win)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (advance) state_next = ST_ISSUE;
            ST_ISSUE: state_next = cmd_we_reg ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (cnt_reg == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= 1'b0;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (advance) begin
                owner_reg     <= win[1];
                cmd_we_reg    <= win[1] ? we1 : we0;
                cmd_addr_reg  <= win[1] ? addr1 : addr0;
                cmd_wdata_reg <= win[1] ? wdata1 : wdata0;
            end
            if ((state_reg == ST_ISSUE) && !cmd_we_reg) begin
                cnt_reg <= CNT_W'(RD_LAT - 1);
            end
            if (state_reg == ST_WAIT) begin
                // counter reaching zero marks the edge where memory data is valid
                if (cnt_reg == '0) begin
                    rdata_reg <= mem_rdata;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_hs
        assign gnt_vec[gi] = (state_reg == ST_ISSUE) && (owner_reg == 1'(gi));
        assign ack_vec[gi] = (state_reg == ST_DONE)  && (owner_reg == 1'(gi));
    end

    assign gnt0 = gnt_vec[REQ_FETCH];
    assign gnt1 = gnt_vec[REQ_DATA];
    assign ack0 = ack_vec[REQ_FETCH];
    assign ack1 = ack_vec[REQ_DATA];

    assign rdata     = rdata_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign mem_addr  = cmd_addr_reg;
    assign mem_wdata = cmd_wdata_reg;
    // gated by Resetn so a reset arriving during ISSUE cannot write
    assign mem_wren  = (state_reg == ST_ISSUE) && cmd_we_reg && Resetn;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RR/RD_LAT=1, fixed/RD_LAT=1, RR/RD_LAT=3)
// each attached to a behavioural memory with a RD_LAT-deep read pipeline.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] resetn_v, req0_v, req1_v, we0_v, we1_v;
    logic [2:0] gnt0_v, gnt1_v, ack0_v, ack1_v, busy_v, wren_v;
    logic [7:0]  addr0_a [3];
    logic [7:0]  addr1_a [3];
    logic [7:0]  maddr_a [3];
    logic [15:0] wdata0_a [3];
    logic [15:0] wdata1_a [3];
    logic [15:0] mwdata_a [3];
    logic [15:0] rdata_a [3];
    logic [15:0] mrdata_a [3];

    logic        mem_clr;
    logic [15:0] mem_arr [3][256];
    logic [15:0] pipe_a [3][3];
    int          wren_cnt [3];
    logic [7:0]  wr_addr_seen [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_arbiter #(
            .DATA_W     (16),
            .ADDR_W     (8),
            .RD_LAT     ((gi == 2) ? 3 : 1),
            .FIXED_PRIO ((gi == 1) ? 1 : 0)
        ) u_dut (
            .Clock     (clk),
            .Resetn    (resetn_v[gi]),
            .req0      (req0_v[gi]),
            .req1      (req1_v[gi]),
            .we0       (we0_v[gi]),
            .we1       (we1_v[gi]),
            .addr0     (addr0_a[gi]),
            .addr1     (addr1_a[gi]),
            .wdata0    (wdata0_a[gi]),
            .wdata1    (wdata1_a[gi]),
            .gnt0      (gnt0_v[gi]),
            .gnt1      (gnt1_v[gi]),
            .ack0      (ack0_v[gi]),
            .ack1      (ack1_v[gi]),
            .rdata     (rdata_a[gi]),
            .busy      (busy_v[gi]),
            .mem_addr  (maddr_a[gi]),
            .mem_wdata (mwdata_a[gi]),
            .mem_wren  (wren_v[gi]),
            .mem_rdata (mrdata_a[gi])
        );
        assign mrdata_a[gi] = pipe_a[gi][(gi == 2) ? 2 : 0];
    end

    // Memory: registered address, data emerges RD_LAT edges after the address edge
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_clr) begin
                for (int m = 0; m < 256; m++) mem_arr[k][m] <= '0;
                wren_cnt[k] <= 0;
                wr_addr_seen[k] <= '0;
            end else if (wren_v[k]) begin
                mem_arr[k][maddr_a[k]] <= mwdata_a[k];
                wren_cnt[k] <= wren_cnt[k] + 1;
                wr_addr_seen[k] <= maddr_a[k];
            end
            pipe_a[k][0] <= mem_arr[k][maddr_a[k]];
            pipe_a[k][1] <= pipe_a[k][0];
            pipe_a[k][2] <= pipe_a[k][1];
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    logic [15:0] ref_mem [3][256];
    int          last_win [3];
    logic [15:0] rd_model [3];

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int model_pick(input logic p0, input logic p1, input int fixed, input int last);
        if (p0 && !p1) return 0;
        if (p1 && !p0) return 1;
        if (fixed != 0) return 1;
        return (last == 1) ? 0 : 1;
    endfunction

    task automatic drop_all(input int idx);
        req0_v[idx] = 1'b0;
        req1_v[idx] = 1'b0;
    endtask

    // Presents up to two requests together and follows them until both are acknowledged.
    task automatic do_round(input int idx, input logic r0, input logic r1,
                            input logic w0, input logic w1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input int exp_first);
        logic p0, p1, first, got, is_we;
        int waitc, owner, exp_owner, wc0;
        logic [7:0] a;
        logic [15:0] d;
        p0 = r0; p1 = r1; first = 1'b1;
        @(negedge clk);
        req0_v[idx] = r0; we0_v[idx] = w0; addr0_a[idx] = a0; wdata0_a[idx] = d0;
        req1_v[idx] = r1; we1_v[idx] = w1; addr1_a[idx] = a1; wdata1_a[idx] = d1;
        while (p0 || p1) begin
            waitc = 0; got = 1'b0;
            while (!got && waitc < 20) begin
                @(negedge clk);
                waitc++;
                if (gnt0_v[idx] || gnt1_v[idx]) got = 1'b1;
            end
            if (!got) begin
                check("gnt_timeout", 0, 1);
                drop_all(idx);
                return;
            end
            exp_owner = first ? exp_first : (p0 ? 0 : 1);
            check("gnt_vec", {ack1_v[idx], ack0_v[idx], gnt1_v[idx], gnt0_v[idx]}, 1 << exp_owner);
            check("gnt_latency", waitc, first ? 1 : 2);
            check("busy_in_txn", busy_v[idx], 1);
            owner = exp_owner;
            last_win[idx] = owner;
            wc0 = wren_cnt[idx];
            if (owner == 0) begin
                req0_v[idx] = 1'b0; p0 = 1'b0; is_we = w0; a = a0; d = d0;
            end else begin
                req1_v[idx] = 1'b0; p1 = 1'b0; is_we = w1; a = a1; d = d1;
            end
            waitc = 0; got = 1'b0;
            while (!got && waitc < 20) begin
                @(negedge clk);
                waitc++;
                if (ack0_v[idx] || ack1_v[idx]) got = 1'b1;
            end
            if (!got) begin
                check("ack_timeout", 0, 1);
                drop_all(idx);
                return;
            end
            check("ack_vec", {ack1_v[idx], ack0_v[idx], gnt1_v[idx], gnt0_v[idx]}, 4 << owner);
            check("ack_latency", waitc, is_we ? 1 : lat_of(idx) + 1);
            if (is_we) begin
                ref_mem[idx][a] = d;
                check("wren_pulses", wren_cnt[idx] - wc0, 1);
                check("wren_addr", wr_addr_seen[idx], a);
                check("mem_word", mem_arr[idx][a], d);
            end else begin
                rd_model[idx] = ref_mem[idx][a];
                check("wren_on_read", wren_cnt[idx] - wc0, 0);
                check("rdata", rdata_a[idx], rd_model[idx]);
            end
            $display("txn inst=%0d req=%0d %s addr=%02h data=%04h", idx, owner,
                     is_we ? "WR" : "RD", a, is_we ? d : rdata_a[idx]);
            first = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", busy_v[idx], 0);
        check("rdata_hold", rdata_a[idx], rd_model[idx]);
    endtask

    typedef struct {
        int          inst;
        logic        r0, r1, w0, w1;
        logic [7:0]  a0, a1;
        logic [15:0] d0, d1;
        int          exp_first;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int any_ack, wc0, ridx;
        logic [1:0] rr;

        for (int k = 0; k < 3; k++) begin
            for (int m = 0; m < 256; m++) ref_mem[k][m] = '0;
            last_win[k] = 1;
            rd_model[k] = '0;
            addr0_a[k] = '0; addr1_a[k] = '0; wdata0_a[k] = '0; wdata1_a[k] = '0;
        end
        req0_v = '1; req1_v = '0; we0_v = '1; we1_v = '0;
        resetn_v = '0;
        mem_clr = 1'b1;

        // Reset held with req0 asserted: nothing may move
        @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("rst_gnt", {gnt1_v[k], gnt0_v[k]}, 0);
                check("rst_ack", {ack1_v[k], ack0_v[k]}, 0);
                check("rst_wren", wren_v[k], 0);
                check("rst_busy", busy_v[k], 0);
                check("rst_rdata", rdata_a[k], 0);
            end
        end
        req0_v = '0; we0_v = '0;
        resetn_v = '1;

        vt[0]  = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h05, 16'h0000, 16'hBEEF, 1, 16'h0000};
        vt[1]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 16'h0000, 16'h0000, 1, 16'hBEEF};
        vt[2]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 8'h10, 16'h0000, 16'h1234, 0, 16'hBEEF};
        vt[3]  = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h10, 16'h0A0A, 16'h0000, 0, 16'h1234};
        vt[4]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 16'h0000, 0, 16'h0A0A};
        vt[5]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h20, 16'h0000, 16'h0000, 1, 16'hBEEF};
        vt[6]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 16'h5555, 16'h0000, 0, 16'hBEEF};
        vt[7]  = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 8'h32, 16'h1111, 16'h2222, 1, 16'hBEEF};
        vt[8]  = '{1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 16'hAAAA, 16'hBBBB, 1, 16'h0000};
        vt[9]  = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 16'h0000, 16'h0000, 1, 16'hAAAA};
        vt[10] = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h40, 16'h0000, 16'hCAFE, 1, 16'h0000};
        vt[11] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 16'h0000, 16'h0000, 0, 16'hCAFE};
        vt[12] = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h41, 16'h0000, 16'h0000, 1, 16'hCAFE};

        for (int i = 0; i < 13; i++) begin
            do_round(vt[i].inst, vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1,
                     vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1, vt[i].exp_first);
            check("row_rdata", rdata_a[vt[i].inst], vt[i].exp_rd);
        end

        // Reset during ISSUE of a write to 8'h07 must abort it without touching memory
        wc0 = wren_cnt[0];
        @(negedge clk);
        req0_v[0] = 1'b1; we0_v[0] = 1'b1; addr0_a[0] = 8'h07; wdata0_a[0] = 16'h7777;
        @(negedge clk);
        check("abort_gnt", gnt0_v[0], 1);
        resetn_v[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_v[0], 0);
        check("abort_hs", {ack1_v[0], ack0_v[0], gnt1_v[0], gnt0_v[0]}, 0);
        req0_v[0] = 1'b0; we0_v[0] = 1'b0;
        @(negedge clk);
        resetn_v[0] = 1'b1;
        last_win[0] = 1;
        rd_model[0] = '0;
        any_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack0_v[0] || ack1_v[0]) any_ack = 1;
        end
        check("abort_no_ack", any_ack, 0);
        check("abort_mem07", mem_arr[0][8'h07], ref_mem[0][8'h07]);
        check("abort_wren", wren_cnt[0] - wc0, 0);
        check("abort_rdata", rdata_a[0], 0);

        // Randomised rounds against the reference model
        for (int n = 0; n < 75; n++) begin
            ridx = n % 3;
            rr = 2'($urandom_range(1, 3));
            do_round(ridx, rr[0], rr[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                     16'($urandom), 16'($urandom),
                     model_pick(rr[0], rr[1], (ridx == 1) ? 1 : 0, last_win[ridx]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
